// File: rtl/instr_encoder.sv
// instr_encoder: streaming RV32I instruction encoder.
// Takes symbolic requests (op, rd, rs1, rs2, imm) over a valid/ready handshake,
// range-checks the immediate, encodes legal requests into 32-bit RV32I words and
// writes them to instruction memory at an auto-incrementing word address.
// Ports:
//   clk, rstn            clock, async active-low reset
//   clr                  sync clear: address, full, err, err_cnt, output stage
//   in_valid/in_ready    request handshake; in_op/in_rd/in_rs1/in_rs2/in_imm payload
//   wr_valid/wr_ready    imem write handshake; wr_addr/wr_data payload
//   full                 all DEPTH slots allocated
//   err/err_cnt          sticky reject flag / saturating reject counter
module instr_encoder #(
  parameter int unsigned BASE_ADDR = 0,
  parameter int unsigned DEPTH     = 128,
  parameter int unsigned AW        = 7
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          clr,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [4:0]    in_op,
  input  logic [4:0]    in_rd,
  input  logic [4:0]    in_rs1,
  input  logic [4:0]    in_rs2,
  input  logic [31:0]   in_imm,
  output logic          wr_valid,
  input  logic          wr_ready,
  output logic [AW-1:0] wr_addr,
  output logic [31:0]   wr_data,
  output logic          full,
  output logic          err,
  output logic [7:0]    err_cnt
);

  localparam int unsigned CW       = AW + 1;
  localparam int unsigned END_ADDR = BASE_ADDR + DEPTH;
  localparam logic [CW-1:0] FIRST_SLOT = CW'(BASE_ADDR);
  localparam logic [CW-1:0] LAST_SLOT  = CW'(END_ADDR - 1);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  localparam logic signed [31:0] I_MIN = -32'sd2048;
  localparam logic signed [31:0] I_MAX = 32'sd2047;
  localparam logic signed [31:0] B_MIN = -32'sd4096;
  localparam logic signed [31:0] B_MAX = 32'sd4094;
  localparam logic signed [31:0] J_MIN = -32'sd1048576;
  localparam logic signed [31:0] J_MAX = 32'sd1048574;

  logic [CW-1:0]      slot_q;   // address the next legal word will take
  logic [31:0]        enc;
  logic               legal;
  logic [2:0]         alu_f3;
  logic               alt;
  logic [2:0]         br_idx;
  logic [2:0]         br_f3;
  logic signed [31:0] imm_s;
  logic               fits_i, fits_sh, fits_b, fits_j, fits_u;
  logic               accept;
  logic               write_done;

  // Shared funct3 for register and immediate ALU ops; alt selects sub/sra/srai.
  always_comb begin
    alu_f3 = 3'b000;
    case (in_op)
      5'd2, 5'd11:               alu_f3 = 3'b100;
      5'd3, 5'd12:               alu_f3 = 3'b110;
      5'd4, 5'd13:               alu_f3 = 3'b111;
      5'd5, 5'd14:               alu_f3 = 3'b001;
      5'd6, 5'd7, 5'd15, 5'd16:  alu_f3 = 3'b101;
      5'd8, 5'd17:               alu_f3 = 3'b010;
      5'd9, 5'd18:               alu_f3 = 3'b011;
      default:                   alu_f3 = 3'b000;
    endcase
  end

  assign alt = (in_op == 5'd1) | (in_op == 5'd7) | (in_op == 5'd16);

  // Branch ops are ordered beq bne blt bge bltu bgeu: funct3 skips 010/011.
  assign br_idx = 3'(in_op - 5'd21);
  assign br_f3  = (br_idx < 3'd2) ? br_idx : br_idx + 3'd2;

  assign imm_s   = $signed(in_imm);
  assign fits_i  = (imm_s >= I_MIN) && (imm_s <= I_MAX);
  assign fits_sh = (in_imm < 32'd32);
  assign fits_b  = (imm_s >= B_MIN) && (imm_s <= B_MAX) && !in_imm[0];
  assign fits_j  = (imm_s >= J_MIN) && (imm_s <= J_MAX) && !in_imm[0];
  assign fits_u  = (in_imm[31:20] == 12'd0);

  // Encode by instruction format and flag requests whose immediate does not fit.
  always_comb begin
    enc   = 32'd0;
    legal = 1'b0;
    if (in_op <= 5'd9) begin
      legal = 1'b1;
      enc   = {alt ? 7'b0100000 : 7'b0000000, in_rs2, in_rs1, alu_f3, in_rd, OPC_OP};
    end else if (in_op >= 5'd14 && in_op <= 5'd16) begin
      legal = fits_sh;
      enc   = {alt ? 7'b0100000 : 7'b0000000, in_imm[4:0], in_rs1, alu_f3, in_rd, OPC_OP_IMM};
    end else if (in_op <= 5'd18) begin
      legal = fits_i;
      enc   = {in_imm[11:0], in_rs1, alu_f3, in_rd, OPC_OP_IMM};
    end else begin
      case (in_op)
        5'd19: begin
          legal = fits_i;
          enc   = {in_imm[11:0], in_rs1, 3'b010, in_rd, OPC_LOAD};
        end
        5'd20: begin
          legal = fits_i;
          enc   = {in_imm[11:5], in_rs2, in_rs1, 3'b010, in_imm[4:0], OPC_STORE};
        end
        5'd21, 5'd22, 5'd23, 5'd24, 5'd25, 5'd26: begin
          legal = fits_b;
          enc   = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, br_f3,
                   in_imm[4:1], in_imm[11], OPC_BRANCH};
        end
        5'd27: begin
          legal = fits_j;
          enc   = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, OPC_JAL};
        end
        5'd28: begin
          legal = fits_i;
          enc   = {in_imm[11:0], in_rs1, 3'b000, in_rd, OPC_JALR};
        end
        5'd29: begin
          legal = fits_u;
          enc   = {in_imm[19:0], in_rd, OPC_LUI};
        end
        default: begin
          legal = 1'b0;
          enc   = 32'd0;
        end
      endcase
    end
  end

  // Ready only when a free slot exists and the output stage can take a word.
  assign in_ready   = rstn & ~full & (~wr_valid | wr_ready) & ~clr;
  assign accept     = in_valid & in_ready;
  assign write_done = wr_valid & wr_ready;

  // Output stage, slot allocation and error bookkeeping; clr wins over everything.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_valid <= 1'b0;
      wr_addr  <= AW'(BASE_ADDR);
      wr_data  <= 32'd0;
      slot_q   <= FIRST_SLOT;
      full     <= 1'b0;
      err      <= 1'b0;
      err_cnt  <= 8'd0;
    end else if (clr) begin
      wr_valid <= 1'b0;
      wr_addr  <= AW'(BASE_ADDR);
      wr_data  <= 32'd0;
      slot_q   <= FIRST_SLOT;
      full     <= 1'b0;
      err      <= 1'b0;
      err_cnt  <= 8'd0;
    end else begin
      if (write_done) begin
        wr_valid <= 1'b0;
      end
      if (accept && legal) begin
        wr_valid <= 1'b1;
        wr_addr  <= slot_q[AW-1:0];
        wr_data  <= enc;
        slot_q   <= slot_q + CW'(1);
        if (slot_q == LAST_SLOT) begin
          full <= 1'b1;
        end
      end
      if (accept && !legal) begin
        err <= 1'b1;
        if (err_cnt != 8'hFF) begin
          err_cnt <= err_cnt + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed and randomized self-checking bench for instr_encoder.
// A behavioural model (format tables + integer range rules) predicts handshake,
// output word, full and error state each cycle; a second DUT with DEPTH=4
// exercises the full/clr path.
module tb_instr_encoder;

  localparam int unsigned AW    = 7;
  localparam int          DEPTH = 128;

  logic          clk = 1'b0;
  logic          rstn, clr, in_valid, in_ready, wr_valid, wr_ready, full, err;
  logic [4:0]    in_op, in_rd, in_rs1, in_rs2;
  logic [31:0]   in_imm, wr_data;
  logic [AW-1:0] wr_addr;
  logic [7:0]    err_cnt;

  logic          clr4, in_valid4, in_ready4, wr_valid4, wr_ready4, full4, err4;
  logic [AW-1:0] wr_addr4;
  logic [31:0]   wr_data4;
  logic [7:0]    err_cnt4;

  always #5 clk = ~clk;

  instr_encoder #(.BASE_ADDR(0), .DEPTH(128), .AW(AW)) dut (
    .clk(clk), .rstn(rstn), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .full(full), .err(err), .err_cnt(err_cnt)
  );

  instr_encoder #(.BASE_ADDR(0), .DEPTH(4), .AW(AW)) dut4 (
    .clk(clk), .rstn(rstn), .clr(clr4), .in_valid(in_valid4), .in_ready(in_ready4),
    .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .wr_valid(wr_valid4), .wr_ready(wr_ready4), .wr_addr(wr_addr4), .wr_data(wr_data4),
    .full(full4), .err(err4), .err_cnt(err_cnt4)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // funct3 per register op: add sub xor or and sll srl sra slt sltu
  logic [31:0] R_F3 [10] = '{32'd0, 32'd0, 32'd4, 32'd6, 32'd7, 32'd1, 32'd5, 32'd5, 32'd2, 32'd3};
  // immediate ALU ops addi xori ori andi slli srli srai slti sltiu -> register-op twin
  int          I_TO_R [9] = '{0, 2, 3, 4, 5, 6, 7, 8, 9};
  // funct3 for beq bne blt bge bltu bgeu
  logic [31:0] B_F3 [6] = '{32'd0, 32'd1, 32'd4, 32'd5, 32'd6, 32'd7};

  // Reference encoder: returns {legal, word}.
  function automatic logic [32:0] ref_enc(input int op, input logic [31:0] rd, rs1, rs2, imm);
    int s;
    logic [31:0] w, f7;
    bit ok;
    s  = $signed(imm);
    w  = 32'd0;
    ok = 1'b1;
    if (op < 10) begin
      f7 = (op == 1 || op == 7) ? 32'h20 : 32'h0;
      w  = (f7 << 25) | (rs2 << 20) | (rs1 << 15) | (R_F3[op] << 12) | (rd << 7) | 32'h33;
    end else if (op >= 14 && op <= 16) begin
      ok = (s >= 0 && s <= 31);
      f7 = (op == 16) ? 32'h20 : 32'h0;
      w  = (f7 << 25) | ((imm & 32'd31) << 20) | (rs1 << 15) | (R_F3[I_TO_R[op-10]] << 12) |
           (rd << 7) | 32'h13;
    end else if (op < 19) begin
      ok = (s >= -2048 && s <= 2047);
      w  = ((imm & 32'hFFF) << 20) | (rs1 << 15) | (R_F3[I_TO_R[op-10]] << 12) | (rd << 7) | 32'h13;
    end else if (op == 19) begin
      ok = (s >= -2048 && s <= 2047);
      w  = ((imm & 32'hFFF) << 20) | (rs1 << 15) | (32'd2 << 12) | (rd << 7) | 32'h03;
    end else if (op == 20) begin
      ok = (s >= -2048 && s <= 2047);
      w  = (((imm >> 5) & 32'd127) << 25) | (rs2 << 20) | (rs1 << 15) | (32'd2 << 12) |
           ((imm & 32'd31) << 7) | 32'h23;
    end else if (op <= 26) begin
      ok = (s >= -4096 && s <= 4094 && (s % 2) == 0);
      w  = (((imm >> 12) & 32'd1) << 31) | (((imm >> 5) & 32'd63) << 25) | (rs2 << 20) |
           (rs1 << 15) | (B_F3[op-21] << 12) | (((imm >> 1) & 32'd15) << 8) |
           (((imm >> 11) & 32'd1) << 7) | 32'h63;
    end else if (op == 27) begin
      ok = (s >= -1048576 && s <= 1048574 && (s % 2) == 0);
      w  = (((imm >> 20) & 32'd1) << 31) | (((imm >> 1) & 32'd1023) << 21) |
           (((imm >> 11) & 32'd1) << 20) | (((imm >> 12) & 32'd255) << 12) | (rd << 7) | 32'h6F;
    end else if (op == 28) begin
      ok = (s >= -2048 && s <= 2047);
      w  = ((imm & 32'hFFF) << 20) | (rs1 << 15) | (rd << 7) | 32'h67;
    end else if (op == 29) begin
      ok = ((imm >> 20) == 32'd0);
      w  = ((imm & 32'hFFFFF) << 12) | (rd << 7) | 32'h37;
    end else begin
      ok = 1'b0;
    end
    return {ok, w};
  endfunction

  // Model state: pending word, next free slot, full, error flag/count.
  bit          m_pv, m_full, m_err;
  int          m_next, m_cnt, m_addr;
  logic [31:0] m_data;

  task automatic model_reset();
    m_pv = 1'b0; m_full = 1'b0; m_err = 1'b0;
    m_next = 0; m_cnt = 0; m_addr = 0; m_data = 32'd0;
  endtask

  // One clock cycle on the main DUT: drive, check against model, advance model.
  task automatic step(input bit v, input logic [4:0] op, rd, rs1, rs2,
                      input logic [31:0] imm, input bit wrr, input bit c);
    logic [32:0] r;
    bit exp_ready;
    in_valid = v; in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_imm = imm; wr_ready = wrr; clr = c;
    #1;
    exp_ready = !m_full && (!m_pv || wrr) && !c;
    check("in_ready", 32'(in_ready), 32'(exp_ready));
    check("wr_valid", 32'(wr_valid), 32'(m_pv));
    if (m_pv) begin
      check("wr_addr", 32'(wr_addr), 32'(m_addr));
      check("wr_data", wr_data, m_data);
    end
    check("full", 32'(full), 32'(m_full));
    check("err", 32'(err), 32'(m_err));
    check("err_cnt", 32'(err_cnt), 32'(m_cnt));
    if (c) begin
      model_reset();
    end else begin
      if (m_pv && wrr) m_pv = 1'b0;
      if (v && exp_ready) begin
        r = ref_enc(int'(op), 32'(rd), 32'(rs1), 32'(rs2), imm);
        if (r[32]) begin
          m_pv = 1'b1; m_addr = m_next; m_data = r[31:0]; m_next++;
          if (m_next == DEPTH) m_full = 1'b1;
        end else begin
          m_err = 1'b1;
          if (m_cnt < 255) m_cnt++;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic req(input logic [4:0] op, rd, rs1, rs2, input logic [31:0] imm);
    step(1'b1, op, rd, rs1, rs2, imm, 1'b1, 1'b0);
  endtask

  task automatic idle(input bit wrr);
    step(1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 32'd0, wrr, 1'b0);
  endtask

  task automatic expect_word(input string tag, input int a, input logic [31:0] d);
    check({tag, ".valid"}, 32'(wr_valid), 32'd1);
    check({tag, ".addr"}, 32'(wr_addr), 32'(a));
    check({tag, ".data"}, wr_data, d);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, ".in_ready"}, 32'(in_ready), 32'd0);
    check({tag, ".wr_valid"}, 32'(wr_valid), 32'd0);
    check({tag, ".wr_addr"}, 32'(wr_addr), 32'd0);
    check({tag, ".wr_data"}, wr_data, 32'd0);
    check({tag, ".full"}, 32'(full), 32'd0);
    check({tag, ".err"}, 32'(err), 32'd0);
    check({tag, ".err_cnt"}, 32'(err_cnt), 32'd0);
  endtask

  logic [31:0] bnd [20] = '{32'd2047, 32'd2048, -32'sd2048, -32'sd2049, 32'd4094, 32'd4095,
                            32'd4096, -32'sd4096, -32'sd4097, -32'sd4098, 32'd1048574,
                            32'd1048576, -32'sd1048576, -32'sd1048578, 32'd31, 32'd32,
                            32'hFFFFFFFF, 32'd0, 32'h000FFFFF, 32'h00100000};

  initial begin
    int acc, wcount;
    logic [31:0] imm;
    rstn = 1'b1; clr = 1'b0; in_valid = 1'b0; wr_ready = 1'b0;
    in_op = 5'd0; in_rd = 5'd0; in_rs1 = 5'd0; in_rs2 = 5'd0; in_imm = 32'd0;
    clr4 = 1'b0; in_valid4 = 1'b0; wr_ready4 = 1'b1;
    #2 rstn = 1'b0;
    #1 check_reset_values("reset");
    @(negedge clk);
    rstn = 1'b1;
    model_reset();

    // first word: addi x1,x0,5
    req(5'd10, 5'd1, 5'd0, 5'd0, 32'd5);
    expect_word("addi", 0, 32'h00500093);
    idle(1'b1);
    step(1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b1, 1'b1);

    // back-to-back stream
    req(5'd0, 5'd3, 5'd1, 5'd2, 32'd0);
    expect_word("add", 0, 32'h002081B3);
    req(5'd1, 5'd3, 5'd1, 5'd2, 32'd0);
    expect_word("sub", 1, 32'h402081B3);
    req(5'd16, 5'd1, 5'd1, 5'd0, 32'd3);
    expect_word("srai", 2, 32'h4030D093);
    req(5'd29, 5'd5, 5'd0, 5'd0, 32'h12345);
    expect_word("lui", 3, 32'h123452B7);

    // store / branch / jump with backpressure on the branch word
    req(5'd20, 5'd0, 5'd1, 5'd2, 32'd8);
    expect_word("sw", 4, 32'h0020A423);
    req(5'd21, 5'd0, 5'd0, 5'd0, 32'd8);
    expect_word("beq", 5, 32'h00000463);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 5'd27, 5'd1, 5'd0, 5'd0, 32'd16, 1'b0, 1'b0);
      expect_word("beq_hold", 5, 32'h00000463);
    end
    step(1'b1, 5'd27, 5'd1, 5'd0, 5'd0, 32'd16, 1'b1, 1'b0);
    expect_word("jal", 6, 32'h010000EF);
    idle(1'b1);

    // rejected requests
    req(5'd10, 5'd1, 5'd0, 5'd0, 32'd2048);
    req(5'd21, 5'd0, 5'd0, 5'd0, 32'd7);
    req(5'd31, 5'd1, 5'd2, 5'd3, 32'd0);
    req(5'd29, 5'd5, 5'd0, 5'd0, 32'h00100000);
    idle(1'b1);
    check("illegal.err", 32'(err), 32'd1);
    check("illegal.err_cnt", 32'(err_cnt), 32'd4);
    check("illegal.wr_valid", 32'(wr_valid), 32'd0);
    req(5'd10, 5'd2, 5'd0, 5'd0, 32'hFFFFFFFF);
    expect_word("after_err", 7, 32'hFFF00113);

    // reset while a word is stalled
    step(1'b1, 5'd10, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0, 1'b0);
    in_valid = 1'b0; wr_ready = 1'b0;
    #1 rstn = 1'b0;
    #1 check_reset_values("mid_reset");
    @(negedge clk);
    rstn = 1'b1;
    model_reset();
    for (int i = 0; i < 3; i++) idle(1'b1);

    // DEPTH=4 instance: five requests, four writes, then clr
    acc = 0; wcount = 0;
    for (int i = 0; i < 8; i++) begin
      in_op = 5'd10; in_rd = 5'd0; in_rs1 = 5'd0; in_imm = 32'(i); in_valid4 = (i < 5);
      #1;
      if (wr_valid4 && wr_ready4) begin
        check("d4.addr", 32'(wr_addr4), 32'(wcount));
        check("d4.data", wr_data4, (32'(wcount) << 20) | 32'h13);
        wcount++;
      end
      if (in_valid4 && in_ready4) acc++;
      @(negedge clk);
    end
    check("d4.accepts", 32'(acc), 32'd4);
    check("d4.writes", 32'(wcount), 32'd4);
    check("d4.full", 32'(full4), 32'd1);
    check("d4.in_ready", 32'(in_ready4), 32'd0);
    check("d4.err", 32'(err4), 32'd0);
    in_valid4 = 1'b0; clr4 = 1'b1;
    @(negedge clk);
    clr4 = 1'b0;
    #1;
    check("d4.clr_full", 32'(full4), 32'd0);
    check("d4.clr_ready", 32'(in_ready4), 32'd1);
    in_valid4 = 1'b1; in_imm = 32'd0;
    @(negedge clk);
    in_valid4 = 1'b0;
    #1;
    check("d4.after_clr_valid", 32'(wr_valid4), 32'd1);
    check("d4.after_clr_addr", 32'(wr_addr4), 32'd0);
    check("d4.err_cnt", 32'(err_cnt4), 32'd0);
    @(negedge clk);

    // randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      case ($urandom_range(0, 4))
        0: imm = 32'($urandom_range(0, 80)) - 32'd40;
        1: imm = bnd[$urandom_range(0, 19)];
        2: imm = $urandom;
        3: imm = 32'($urandom_range(0, 31));
        default: imm = $urandom & 32'h001FFFFF;
      endcase
      step($urandom_range(0, 9) < 8, 5'($urandom_range(0, 31)), 5'($urandom), 5'($urandom),
           5'($urandom), imm, $urandom_range(0, 3) != 0, $urandom_range(0, 399) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
